// File: rtl/dmem_dbg_pkg.sv
// Shared constants for the data-memory debug arbiter: FSM state encoding and
// default memory geometry.
package dmem_dbg_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND    = 2'd1,
        S_ISSUE   = 2'd2,
        S_CAPTURE = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous board switch plus a one-cycle
// rising-edge pulse on the synchronized level.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/dmem_debug_arbiter.sv
// Shares the data memory between the MEM stage (priority) and the debug probe.
// Define DMEM_HACK_REFRESH_EN to re-read the debug address periodically while hack is held.
module dmem_debug_arbiter
    import dmem_dbg_pkg::*;
#(
    parameter int AW             = AW_DEF,
    parameter int DW             = DW_DEF,
    parameter int STARVE_LIMIT   = 8,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          hack,
    input  logic [AW-1:0] dbg_addr,
    input  logic [1:0]    byte_sel,
    output logic [7:0]    led,
    output logic          dbg_busy
);

    dbg_state_e    state_q, state_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic [AW-1:0] dbg_addr_q, dbg_addr_d;
    logic [DW-1:0] dbg_word_q;
    logic          cpu_rvalid_q;
    logic          hack_lvl, hack_rise, dbg_start;

    sync_edge_detect u_hack_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (hack),
        .level_o (hack_lvl),
        .rise_o  (hack_rise)
    );

`ifdef DMEM_HACK_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES);
    logic [RW-1:0] refresh_cnt_q;
    logic          refresh_hit;

    // Counter only advances while idle, so a slow CPU never piles up refreshes.
    assign refresh_hit = hack_lvl && (state_q == S_IDLE) &&
                         (refresh_cnt_q == RW'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            refresh_cnt_q <= '0;
        else if (!hack_lvl || refresh_hit)
            refresh_cnt_q <= '0;
        else if (state_q == S_IDLE)
            refresh_cnt_q <= refresh_cnt_q + 1'b1;
    end

    assign dbg_start = hack_rise | refresh_hit;
`else
    logic unused_hack_lvl;
    assign unused_hack_lvl = hack_lvl;
    assign dbg_start       = hack_rise;
`endif

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dbg_addr_d   = dbg_addr_q;
        mem_en       = cpu_req;
        mem_we       = cpu_we;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        cpu_stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbg_start) begin
                    dbg_addr_d = dbg_addr;
                    state_d    = S_PEND;
                end
            end
            S_PEND: begin
                // Take any idle CPU cycle; otherwise force a slot after STARVE_LIMIT.
                if (!cpu_req) begin
                    state_d      = S_ISSUE;
                    starve_cnt_d = '0;
                end else if (starve_cnt_q + 8'd1 == 8'(STARVE_LIMIT)) begin
                    state_d      = S_ISSUE;
                    starve_cnt_d = '0;
                end else begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b0;
                mem_addr  = dbg_addr_q;
                cpu_stall = cpu_req;
                state_d   = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            starve_cnt_q <= '0;
            dbg_addr_q   <= '0;
            dbg_word_q   <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dbg_addr_q   <= dbg_addr_d;
            cpu_rvalid_q <= cpu_req & ~cpu_we & ~cpu_stall;
            if (state_q == S_CAPTURE)
                dbg_word_q <= mem_rdata;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_rvalid = cpu_rvalid_q;
    assign led        = dbg_word_q[8*byte_sel +: 8];
    assign dbg_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_debug_arbiter.sv
// Directed and random checks of dmem_debug_arbiter against a cycle-numbered
// transaction model and a shadow copy of the data memory.
module tb_dmem_debug_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_stall, cpu_rvalid, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          hack = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [1:0]    byte_sel = '0;
    logic [7:0]    led;
    logic          dbg_busy;

    always #5 clk = ~clk;

    dmem_debug_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .REFRESH_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .cpu_rvalid(cpu_rvalid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hack(hack), .dbg_addr(dbg_addr),
        .byte_sel(byte_sel), .led(led), .dbg_busy(dbg_busy)
    );

    // Single-port synchronous RAM behind the arbiter.
    logic [DW-1:0] mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: a debug transaction is a set of cycle numbers (pend start, issue,
    // capture) derived from the CPU request trace and the hack edge timing.
    int            cyc = 0, issue = -1, blocked = 0;
    bit            act = 0, h1 = 0, h2 = 0, h3 = 0, rv_exp = 0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] dbg_exp = '0, cap_val = '0, rd_exp = '0;
    logic [DW-1:0] ref_mem [64] = '{default: '0};

    int   stall_n = 0, stall_at = -100, busy_at = -100, dbg_en_n = 0, dbg_en_at = -100;
    bit   busy_prev = 0;
    logic we_at_stall = 1'b1, rv_post = 1'b1;

    task automatic mreset();
        act = 0; issue = -1; blocked = 0;
        h1 = 0; h2 = 0; h3 = 0;
        dbg_exp = '0; rv_exp = 0;
    endtask

    // Inputs are set at the falling edge; check, let one rising edge pass, update.
    task automatic step();
        bit          in_issue, st;
        logic [31:0] w;
        #1;
        if (!rst_n) mreset();
        in_issue = act && (issue == cyc);
        st = in_issue && cpu_req;
        chk("cpu_stall", 32'(cpu_stall), 32'(st));
        chk("mem_en", 32'(mem_en), in_issue ? 32'd1 : 32'(cpu_req));
        chk("mem_we", 32'(mem_we), in_issue ? 32'd0 : 32'(cpu_we));
        chk("mem_addr", 32'(mem_addr), in_issue ? 32'(maddr) : 32'(cpu_addr));
        if (!in_issue) chk("mem_wdata", mem_wdata, cpu_wdata);
        w = dbg_exp;
        chk("led", 32'(led), 32'(w[8*byte_sel +: 8]));
        chk("dbg_busy", 32'(dbg_busy), 32'(act));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(rv_exp));
        if (rv_exp) chk("cpu_rdata", cpu_rdata, rd_exp);

        if (cpu_stall) begin stall_n++; stall_at = cyc; we_at_stall = mem_we; end
        if (cyc == stall_at + 1) rv_post = cpu_rvalid;
        if (dbg_busy && !busy_prev) busy_at = cyc;
        busy_prev = dbg_busy;
        if (mem_en && !cpu_req) begin dbg_en_n++; dbg_en_at = cyc; end

        @(posedge clk);
        if (rst_n) begin
            if (cpu_req && !cpu_we && !st) rd_exp = ref_mem[cpu_addr];
            rv_exp = cpu_req && !cpu_we && !st;
            if (in_issue) cap_val = ref_mem[maddr];
            if (cpu_req && cpu_we && !in_issue) ref_mem[cpu_addr] = cpu_wdata;
            if (act && issue == cyc - 1) begin
                dbg_exp = cap_val;
                act = 0;
            end else if (act && issue < 0) begin
                if (!cpu_req) issue = cyc + 1;
                else begin
                    blocked++;
                    if (blocked == LIMIT) issue = cyc + 1;
                end
            end else if (!act && h2 && !h3) begin
                act = 1; issue = -1; blocked = 0; maddr = dbg_addr;
            end
            h3 = h2; h2 = h1; h1 = hack;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (!dbg_busy && n < 10) begin step(); n++; end
        chk(tag, 32'(dbg_busy), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] v2;
        @(negedge clk);

        // Reset state
        rst_n = 1'b0;
        step(); step();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(dbg_busy), 32'd0);
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        rst_n = 1'b1;
        step();

        // Idle CPU: best-case debug read, byte select, late dbg_addr change
        cpu_req = 1; cpu_we = 1; cpu_addr = 5; cpu_wdata = 32'h11223344;
        step();
        cpu_req = 0; cpu_we = 0; hack = 1; dbg_addr = 5; byte_sel = 0;
        repeat (4) step();
        dbg_addr = 9;
        repeat (2) step();
        chk("idle_led_b0", 32'(led), 32'h44);
        byte_sel = 3;
        #1 chk("idle_led_b3", 32'(led), 32'h11);
        hack = 0; byte_sel = 0;
        repeat (4) step();

        // Busy CPU: forced slot after LIMIT blocked cycles
        v2 = $urandom;
        cpu_req = 1; cpu_we = 1; cpu_addr = 2; cpu_wdata = v2;
        step();
        cpu_we = 0; cpu_addr = 3; hack = 1; dbg_addr = 2; stall_n = 0;
        repeat (20) step();
        chk("busy_stall_cnt", 32'(stall_n), 32'd1);
        chk("busy_stall_dist", 32'(stall_at - busy_at), 32'(LIMIT));
        chk("busy_rvalid_post", 32'(rv_post), 32'd0);
        chk("busy_led", 32'(led), 32'(v2[7:0]));
        hack = 0;
        repeat (3) step();

        // Stalled write during the forced slot
        cpu_we = 1; cpu_addr = 7; cpu_wdata = 32'hAA; hack = 1; dbg_addr = 7; stall_n = 0;
        repeat (20) step();
        chk("wr_stall_cnt", 32'(stall_n), 32'd1);
        chk("wr_mem_we_stall", 32'(we_at_stall), 32'd0);
        chk("wr_mem7", mem[7], 32'hAA);
        cpu_req = 0; cpu_we = 0; hack = 0;
        repeat (3) step();
        hack = 1;
        repeat (8) step();
        chk("wr_led7", 32'(led), 32'hAA);
        hack = 0;
        repeat (3) step();

        // Gap opportunism after 3 blocked PEND cycles
        cpu_req = 1; cpu_addr = 1; hack = 1; dbg_addr = 5; stall_n = 0; dbg_en_n = 0;
        wait_busy("gap_busy");
        repeat (3) step();
        cpu_req = 0;
        repeat (2) step();
        cpu_req = 1;
        repeat (6) step();
        chk("gap_stall_cnt", 32'(stall_n), 32'd0);
        chk("gap_issue_dist", 32'(dbg_en_at - busy_at), 32'd4);
        chk("gap_issue_cnt", 32'(dbg_en_n), 32'd1);
        hack = 0;
        repeat (3) step();

        // Second hack edge while busy is dropped
        hack = 1; dbg_addr = 2; stall_n = 0;
        wait_busy("dbl_busy");
        hack = 0; step();
        hack = 1; step();
        repeat (25) step();
        chk("dbl_stall_cnt", 32'(stall_n), 32'd1);
        hack = 0;
        repeat (3) step();

        // Reset during PEND, then a fresh transaction
        hack = 1; dbg_addr = 2;
        wait_busy("rst_pend_busy");
        repeat (2) step();
        rst_n = 0; cpu_req = 0; hack = 0;
        #1;
        chk("rst_pend_busy0", 32'(dbg_busy), 32'd0);
        chk("rst_pend_led0", 32'(led), 32'd0);
        dbg_en_n = 0;
        step(); step();
        rst_n = 1;
        repeat (12) step();
        chk("rst_no_dbg_en", 32'(dbg_en_n), 32'd0);
        hack = 1; dbg_addr = 5; byte_sel = 2;
        repeat (8) step();
        chk("rst_fresh_led", 32'(led), 32'h22);
        hack = 0;
        repeat (3) step();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = AW'($urandom_range(0, 63));
            cpu_wdata = $urandom;
            byte_sel  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dbg_addr = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 11) == 0) hack = ~hack;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_debug_arbiter.md
Name: dmem_debug_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and the board debug probe (Hack switch, DataMemAddr switches, Led bank).
- The CPU has priority. A starvation guard forces one debug slot, stalling the CPU, after STARVE_LIMIT blocked cycles.
- The debug read result is latched, and one selected byte is driven onto the LEDs.
- Sits between the MEM stage and the data memory instance inside top.

Parameters:
- AW, 6, data memory address width (word address).
- DW, 32, data word width.
- STARVE_LIMIT, 8, consecutive blocked debug cycles before a forced debug slot (range 1..255).
- REFRESH_CYCLES, 1024, re-read interval while the optional feature is enabled (≥4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  MEM stage requests memory this cycle.
- cpu_we  in  1  request is a write.
- cpu_addr  in  AW  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_stall  out  1  CPU request not serviced this cycle; MEM stage must hold.
- cpu_rdata  out  DW  read data (equals mem_rdata).
- cpu_rvalid  out  1  cpu_rdata valid (registered: granted CPU read in previous cycle).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, 1-cycle synchronous latency.
- hack  in  1  debug switch (asynchronous; level).
- dbg_addr  in  AW  debug address switches (DataMemAddr).
- byte_sel  in  2  selects byte of latched debug word shown on led (0 = bits 7:0).
- led  out  8  displayed byte.
- dbg_busy  out  1  debug transaction in progress (state ≠ IDLE).

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - starve_cnt=0, dbg_word=0, so led=0.
  - cpu_rvalid=0, dbg_busy=0.
  - Sync flops for hack are cleared.
  - Reset mid-transaction abandons it; no memory access is issued after reset asserts.
- hack path: 2-flop synchronizer, then rising-edge detect (hack_rise). dbg_addr is sampled when hack_rise is seen in IDLE.
- FSM IDLE:
  - Memory port follows the CPU: mem_en=cpu_req, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - cpu_stall=0.
  - On hack_rise: latch the address and go to PEND.
- FSM PEND:
  - CPU still owns the port.
  - If cpu_req=0 this cycle, go to ISSUE next cycle.
  - Otherwise increment starve_cnt. When starve_cnt reaches STARVE_LIMIT, go to ISSUE and clear starve_cnt.
- FSM ISSUE (exactly 1 cycle):
  - Memory driven by debug: mem_en=1, mem_we=0, mem_addr=latched address.
  - cpu_stall=cpu_req. A stalled CPU write is not performed.
  - Go to CAPTURE.
- FSM CAPTURE (1 cycle):
  - dbg_word<=mem_rdata at the end of this cycle; return to IDLE.
  - CPU owns the port again; cpu_stall=0.
- cpu_rvalid: cpu_rvalid<=granted & cpu_req & ~cpu_we, where granted means not stalled.
- Debug read latency: worst case hack_rise + STARVE_LIMIT + 2 cycles; best case 2 cycles after entering PEND.
- led = dbg_word[8*byte_sel +: 8], combinational from register; byte_sel changes take effect immediately.
- hack_rise while dbg_busy=1 is ignored (not queued).
- Changing dbg_addr after the latch has no effect on the pending transaction.
- cpu_stall is only ever high in ISSUE, so the CPU loses at most 1 cycle per debug transaction.

Optional Feature:
- Macro: DMEM_HACK_REFRESH_EN.
- Defined:
  - A refresh counter runs while synchronized hack=1 and state=IDLE.
  - Every REFRESH_CYCLES cycles it re-samples dbg_addr and enters PEND, so the LEDs track memory and address changes live.
  - Counter clears when hack=0.
- Undefined:
  - Exactly one debug read per hack rising edge.
  - No refresh counter logic is present.

Decomposition:
- Shared package dmem_dbg_pkg:
  - State encoding constants S_IDLE, S_PEND, S_ISSUE, S_CAPTURE.
  - Default AW/DW.
- One natural sub-module: sync_edge_detect (2-flop synchronizer plus rising-edge pulse), reusable for other board switches.

Test Plan:
- Idle CPU: write mem[5]=0x11223344 via CPU, then hack 0→1 with dbg_addr=5, cpu_req=0, byte_sel=0:
  - led=0x44 within 6 cycles of the hack edge.
  - byte_sel=3 then gives led=0x11.
- Busy CPU, STARVE_LIMIT=8: cpu_req held 1 (reads), debug read of addr 2:
  - cpu_stall pulses high exactly 1 cycle, 8 cycles after PEND entry.
  - cpu_rvalid low the cycle after the stall.
  - led updates one cycle after the stall.
- Stalled write: cpu_we=1, cpu_addr=7, data 0xAA during the forced slot:
  - mem_we=0 that cycle.
  - Write succeeds the next cycle after the CPU holds; mem[7]=0xAA.
- Gap opportunism: cpu_req drops for 1 cycle after 3 PEND cycles:
  - ISSUE occurs in the next cycle with no cpu_stall.
  - starve_cnt not used for the issue.
- Second hack edge while dbg_busy=1: ignored; only one ISSUE cycle observed.
- Reset asserted during PEND:
  - Immediately IDLE, led=0, no debug mem_en afterwards.
  - A fresh hack edge after reset works normally.
